// File: rtl/yuv_pkg.sv
// Shared Y'UV pixel/word layouts and helpers for the 444<->422 stream converters.
// Holds the 444 pixel and 422 word typedefs, byte-lane indices, keep masks,
// the packer state encoding and the rounded chroma mean.
package yuv_pkg;

  localparam int unsigned PX_WIDTH   = 32;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned PAIR_WIDTH = 2 * PX_WIDTH;

  // Byte lanes inside one 32-bit 444 pixel.
  localparam int unsigned LANE_V = 0;
  localparam int unsigned LANE_U = 1;
  localparam int unsigned LANE_Y = 2;

  // Byte lanes inside one 32-bit 422 word.
  localparam int unsigned WLANE_Y0 = 0;
  localparam int unsigned WLANE_U  = 1;
  localparam int unsigned WLANE_Y1 = 2;
  localparam int unsigned WLANE_V  = 3;

  localparam logic [7:0] KEEP_FULL = 8'hFF;
  localparam logic [7:0] KEEP_TAIL = 8'h0F;

  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
  } yuv444_px_t;

  typedef struct packed {
    logic [7:0] v;
    logic [7:0] y1;
    logic [7:0] u;
    logic [7:0] y0;
  } yuv422_word_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pack_state_e;

  // Rounded mean, round-half-up; 9-bit sum so 0xFF+0xFF stays 0xFF.
  function automatic logic [7:0] chroma_avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = 9'(a) + 9'(b) + 9'd1;
    return sum[8:1];
  endfunction

endpackage

// File: rtl/nasti_stream_channel.sv
// NASTI stream channel bundle: data/keep/strb/last/user/dest/id with valid/ready.
// master drives payload+valid and samples ready; slave is the mirror.
interface nasti_stream_channel #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 1
);
  logic [DATA_WIDTH-1:0]   t_data;
  logic [DATA_WIDTH/8-1:0] t_keep;
  logic [DATA_WIDTH/8-1:0] t_strb;
  logic                    t_last;
  logic [USER_WIDTH-1:0]   t_user;
  logic [DEST_WIDTH-1:0]   t_dest;
  logic [ID_WIDTH-1:0]     t_id;
  logic                    t_valid;
  logic                    t_ready;

  modport master (
    output t_data, t_keep, t_strb, t_last, t_user, t_dest, t_id, t_valid,
    input  t_ready
  );

  modport slave (
    input  t_data, t_keep, t_strb, t_last, t_user, t_dest, t_id, t_valid,
    output t_ready
  );
endinterface

// File: rtl/yuv444_pair_reduce.sv
// Combinational reduction of one 444 pixel pair to one packed 422 word.
// Ports:
//   pair_i  64-bit beat, pixel 0 in [31:0], pixel 1 in [63:32] (V,U,Y,pad per pixel)
//   word_c  422 word {V, Y1, U, Y0}
// AVERAGE=1 takes the rounded mean of both chroma samples, AVERAGE=0 keeps pixel 0's.
module yuv444_pair_reduce
  import yuv_pkg::*;
#(
  parameter bit AVERAGE = 1'b1
) (
  input  logic [PAIR_WIDTH-1:0] pair_i,
  output yuv422_word_t          word_c
);

  yuv444_px_t px0;
  yuv444_px_t px1;
  logic       unused_bits;

  assign px0 = yuv444_px_t'(pair_i[PX_WIDTH-1:0]);
  assign px1 = yuv444_px_t'(pair_i[PAIR_WIDTH-1:PX_WIDTH]);

  // Pad bytes never reach the output; pixel-1 chroma is dropped when not averaging.
  assign unused_bits = ^{px0.pad, px1.pad, px1.u, px1.v};

  always_comb begin
    word_c    = '0;
    word_c.y0 = px0.y;
    word_c.y1 = px1.y;
    if (AVERAGE) begin
      word_c.u = chroma_avg(px0.u, px1.u);
      word_c.v = chroma_avg(px0.v, px1.v);
    end else begin
      word_c.u = px0.u;
      word_c.v = px0.v;
    end
  end

endmodule

// File: rtl/yuv444to422_packer.sv
// Y'UV444 -> Y'UV422 stream packer: two 444 pixels per input beat become one
// 422 word, and two words fill one 64-bit output beat. An odd word ending a
// packet goes out alone in the low half with keep/strb = 8'h0F.
// Ports:
//   aclk, aresetn  clock, async active-low reset
//   src            444 input stream (slave)
//   dst            422 output stream (master), registered payload and valid
module yuv444to422_packer
  import yuv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter bit          AVERAGE    = 1'b1
) (
  input logic                 aclk,
  input logic                 aresetn,
  nasti_stream_channel.slave  src,
  nasti_stream_channel.master dst
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned HALF_WIDTH = DATA_WIDTH / 2;

  if (DATA_WIDTH != 64) begin : g_bad_width
    $error("yuv444to422_packer: only DATA_WIDTH=64 is supported");
  end

  pack_state_e             state_q, state_d;
  logic [HALF_WIDTH-1:0]   half_q, half_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [KEEP_WIDTH-1:0]   keep_q, keep_d;
  logic [KEEP_WIDTH-1:0]   strb_q, strb_d;
  logic                    last_q, last_d;
  logic [USER_WIDTH-1:0]   user_q, user_d;
  logic [DEST_WIDTH-1:0]   dest_q, dest_d;

  yuv422_word_t word_c;
  logic         src_ready_c;
  logic         accept_c;
  logic         unused_src_id;

  yuv444_pair_reduce #(
    .AVERAGE (AVERAGE)
  ) u_reduce (
    .pair_i (src.t_data),
    .word_c (word_c)
  );

  // Ready depends only on the output register, never on src.t_valid.
  assign src_ready_c   = !valid_q || dst.t_ready;
  assign accept_c      = src.t_valid && src_ready_c;
  assign src.t_ready   = src_ready_c;
  assign unused_src_id = ^src.t_id;

  assign dst.t_valid = valid_q;
  assign dst.t_data  = data_q;
  assign dst.t_keep  = keep_q;
  assign dst.t_strb  = strb_q;
  assign dst.t_last  = last_q;
  assign dst.t_user  = user_q;
  assign dst.t_dest  = dest_q;
  assign dst.t_id    = '0;

  // Partial-lane input is flagged but still processed as a full beat.
  always @(posedge aclk) begin
    if (aresetn && accept_c) begin
      assert (&src.t_keep && &src.t_strb)
        else $error("yuv444to422_packer: src t_keep/t_strb not all-ones (keep=%h strb=%h)",
                    src.t_keep, src.t_strb);
    end
  end

  // Pairing FSM and output register load/clear.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    strb_d  = strb_q;
    last_d  = last_q;
    user_d  = user_q;
    dest_d  = dest_q;

    if (valid_q && dst.t_ready) begin
      valid_d = 1'b0;
    end

    if (accept_c) begin
      unique case (state_q)
        ST_EMPTY: begin
          if (src.t_last) begin
            valid_d = 1'b1;
            data_d  = {{HALF_WIDTH{1'b0}}, word_c};
            keep_d  = KEEP_TAIL;
            strb_d  = KEEP_TAIL;
            last_d  = 1'b1;
            user_d  = src.t_user;
            dest_d  = src.t_dest;
          end else begin
            half_d  = word_c;
            state_d = ST_HALF;
          end
        end
        ST_HALF: begin
          valid_d = 1'b1;
          data_d  = {word_c, half_q};
          keep_d  = KEEP_FULL;
          strb_d  = KEEP_FULL;
          last_d  = src.t_last;
          user_d  = src.t_user;
          dest_d  = src.t_dest;
          state_d = ST_EMPTY;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_EMPTY;
      half_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      strb_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      strb_q  <= strb_d;
      last_q  <= last_d;
      user_q  <= user_d;
      dest_q  <= dest_d;
    end
  end

endmodule

// File: tb/tb_yuv444to422_packer.sv
// Bench for yuv444to422_packer: an averaging instance under test with
// backpressure, and a dropping instance that mirrors its accepted beats.
module tb_yuv444to422_packer;
  import yuv_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [7:0]  strb;
    logic        last;
    logic        user;
    logic        dest;
  } beat_t;

  localparam logic [63:0] B1 = 64'h00402312_00302010;
  localparam logic [63:0] B2 = 64'h00A0FF02_00500001;
  localparam logic [63:0] B3 = 64'h0011FFFF_0022FFFF;

  logic aclk;
  logic aresetn;
  int   checks;
  int   errors;
  int   cyc;

  nasti_stream_channel #(.DATA_WIDTH(64), .USER_WIDTH(1), .DEST_WIDTH(1)) src_if ();
  nasti_stream_channel #(.DATA_WIDTH(64), .USER_WIDTH(1), .DEST_WIDTH(1)) dst_if ();
  nasti_stream_channel #(.DATA_WIDTH(64), .USER_WIDTH(1), .DEST_WIDTH(1)) src0_if ();
  nasti_stream_channel #(.DATA_WIDTH(64), .USER_WIDTH(1), .DEST_WIDTH(1)) dst0_if ();

  yuv444to422_packer #(.AVERAGE(1'b1)) dut (
    .aclk (aclk), .aresetn (aresetn), .src (src_if), .dst (dst_if)
  );

  yuv444to422_packer #(.AVERAGE(1'b0)) dut_drop (
    .aclk (aclk), .aresetn (aresetn), .src (src0_if), .dst (dst0_if)
  );

  // The dropping instance takes exactly the beats the main instance accepts.
  assign src0_if.t_data  = src_if.t_data;
  assign src0_if.t_keep  = src_if.t_keep;
  assign src0_if.t_strb  = src_if.t_strb;
  assign src0_if.t_last  = src_if.t_last;
  assign src0_if.t_user  = src_if.t_user;
  assign src0_if.t_dest  = src_if.t_dest;
  assign src0_if.t_id    = src_if.t_id;
  assign src0_if.t_valid = src_if.t_valid && src_if.t_ready;
  assign dst0_if.t_ready = 1'b1;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_word(input logic [63:0] b, input bit avg);
    int unsigned y0, u0, v0, y1, u1, v1, u, v;
    logic [31:0] w;
    y0 = 32'(b[8*LANE_Y +: 8]);
    u0 = 32'(b[8*LANE_U +: 8]);
    v0 = 32'(b[8*LANE_V +: 8]);
    y1 = 32'(b[32+8*LANE_Y +: 8]);
    u1 = 32'(b[32+8*LANE_U +: 8]);
    v1 = 32'(b[32+8*LANE_V +: 8]);
    if (avg) begin
      u = (u0 + u1 + 1) / 2;
      v = (v0 + v1 + 1) / 2;
    end else begin
      u = u0;
      v = v0;
    end
    w = '0;
    w[8*WLANE_Y0 +: 8] = 8'(y0);
    w[8*WLANE_U  +: 8] = 8'(u);
    w[8*WLANE_Y1 +: 8] = 8'(y1);
    w[8*WLANE_V  +: 8] = 8'(v);
    return w;
  endfunction

  beat_t       q0[$];
  beat_t       q1[$];
  logic [31:0] pend_w[2];
  bit          pend_v[2];
  bit          lat_pend[2];
  beat_t       last_out[2];
  int          out_cnt[2];
  bit          prev_stall;
  beat_t       held;

  // Words of a packet are paired in order; an odd final word goes out alone.
  task automatic model_accept(input int ch, input logic [63:0] d, input logic l,
                              input logic u, input logic de, output bit emit);
    beat_t b;
    logic [31:0] w;
    w = model_word(d, ch == 1);
    emit = 1'b0;
    b.user = u;
    b.dest = de;
    if (pend_v[ch]) begin
      b.data = {w, pend_w[ch]};
      b.keep = 8'hFF;
      b.strb = 8'hFF;
      b.last = l;
      emit = 1'b1;
      pend_v[ch] = 1'b0;
    end else if (l) begin
      b.data = {32'h0, w};
      b.keep = 8'h0F;
      b.strb = 8'h0F;
      b.last = 1'b1;
      emit = 1'b1;
    end else begin
      pend_w[ch] = w;
      pend_v[ch] = 1'b1;
    end
    if (emit) begin
      if (ch == 1) q1.push_back(b);
      else q0.push_back(b);
    end
  endtask

  task automatic pop_check(input int ch, input beat_t act);
    beat_t e;
    int sz;
    sz = (ch == 1) ? q1.size() : q0.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_out_ch%0d: actual=%h required=none", ch, act.data);
    end else begin
      e = (ch == 1) ? q1.pop_front() : q0.pop_front();
      chk($sformatf("out_data_ch%0d", ch), act.data, e.data);
      chk($sformatf("out_keep_ch%0d", ch), 64'(act.keep), 64'(e.keep));
      chk($sformatf("out_strb_ch%0d", ch), 64'(act.strb), 64'(e.strb));
      chk($sformatf("out_last_ch%0d", ch), 64'(act.last), 64'(e.last));
      chk($sformatf("out_user_ch%0d", ch), 64'(act.user), 64'(e.user));
      chk($sformatf("out_dest_ch%0d", ch), 64'(act.dest), 64'(e.dest));
    end
    last_out[ch] = act;
    out_cnt[ch]++;
  endtask

  // Compare process, mid-cycle: the handshakes seen here happen at the next rising edge.
  always @(negedge aclk) begin
    beat_t cur1, cur0;
    bit emit;
    if (!aresetn) begin
      q0.delete();
      q1.delete();
      pend_v[0] = 1'b0; pend_v[1] = 1'b0;
      lat_pend[0] = 1'b0; lat_pend[1] = 1'b0;
      prev_stall = 1'b0;
    end else begin
      cur1 = '{dst_if.t_data, dst_if.t_keep, dst_if.t_strb, dst_if.t_last,
               dst_if.t_user, dst_if.t_dest};
      cur0 = '{dst0_if.t_data, dst0_if.t_keep, dst0_if.t_strb, dst0_if.t_last,
               dst0_if.t_user, dst0_if.t_dest};
      chk("src_ready_rule", 64'(src_if.t_ready), 64'(!dst_if.t_valid || dst_if.t_ready));
      if (lat_pend[1]) chk("latency_ch1", 64'(dst_if.t_valid), 64'd1);
      if (lat_pend[0]) chk("latency_ch0", 64'(dst0_if.t_valid), 64'd1);
      if (prev_stall) begin
        chk("stall_valid", 64'(dst_if.t_valid), 64'd1);
        chk("stall_data", cur1.data, held.data);
        chk("stall_meta", 64'(cur1[18:0]), 64'(held[18:0]));
      end
      if (dst_if.t_valid && dst_if.t_ready) pop_check(1, cur1);
      if (dst0_if.t_valid && dst0_if.t_ready) pop_check(0, cur0);
      prev_stall = dst_if.t_valid && !dst_if.t_ready;
      held = cur1;
      lat_pend[1] = 1'b0;
      lat_pend[0] = 1'b0;
      if (src_if.t_valid && src_if.t_ready) begin
        model_accept(1, src_if.t_data, src_if.t_last, src_if.t_user, src_if.t_dest, emit);
        lat_pend[1] = emit;
      end
      if (src0_if.t_valid && src0_if.t_ready) begin
        model_accept(0, src0_if.t_data, src0_if.t_last, src0_if.t_user, src0_if.t_dest, emit);
        lat_pend[0] = emit;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send(input logic [63:0] d, input logic l, input logic u, input logic de);
    src_if.t_data  = d;
    src_if.t_last  = l;
    src_if.t_user  = u;
    src_if.t_dest  = de;
    src_if.t_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (src_if.t_ready) begin
        @(posedge aclk);
        #1;
        src_if.t_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: actual=no_ready required=ready");
    src_if.t_valid = 1'b0;
  endtask

  task automatic wait_out(input int ch, input int target);
    for (int i = 0; i < 50; i++) begin
      if (out_cnt[ch] >= target) return;
      @(posedge aclk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL wait_out_ch%0d: actual=%0d required=%0d", ch, out_cnt[ch], target);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(dst_if.t_valid), 64'd0);
    chk({tag, "_data"},  dst_if.t_data, 64'd0);
    chk({tag, "_keep"},  64'(dst_if.t_keep), 64'd0);
    chk({tag, "_strb"},  64'(dst_if.t_strb), 64'd0);
    chk({tag, "_last"},  64'(dst_if.t_last), 64'd0);
    chk({tag, "_user"},  64'(dst_if.t_user), 64'd0);
    chk({tag, "_dest"},  64'(dst_if.t_dest), 64'd0);
    chk({tag, "_src_ready"}, 64'(src_if.t_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, t0;
    checks = 0; errors = 0; cyc = 0;
    out_cnt[0] = 0; out_cnt[1] = 0;
    src_if.t_valid = 1'b0;
    src_if.t_data  = '0;
    src_if.t_keep  = 8'hFF;
    src_if.t_strb  = 8'hFF;
    src_if.t_last  = 1'b0;
    src_if.t_user  = 1'b0;
    src_if.t_dest  = 1'b0;
    src_if.t_id    = 1'b0;
    dst_if.t_ready = 1'b1;
    aresetn = 1'b1;
    #2 aresetn = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    aresetn = 1'b1;
    idle(1);

    // Hand-computed pins for the model itself.
    chk("pin_model_avg",  64'(model_word(B1, 1'b1)), 64'h11402230);
    chk("pin_model_drop", 64'(model_word(B1, 1'b0)), 64'h10402030);
    chk("pin_model_b3",   64'(model_word(B3, 1'b1)), 64'hFF11FF22);

    // Pair: rounding FF/00 -> 80, 01/02 -> 02.
    c1 = out_cnt[1]; c0 = out_cnt[0];
    send(B1, 1'b0, 1'b1, 1'b0);
    send(B2, 1'b1, 1'b0, 1'b1);
    wait_out(1, c1 + 1);
    chk("pair_avg_data", last_out[1].data, 64'h02A08050_11402230);
    chk("pair_avg_keep", 64'(last_out[1].keep), 64'hFF);
    chk("pair_avg_last", 64'(last_out[1].last), 64'd1);
    chk("pair_avg_dest", 64'(last_out[1].dest), 64'd1);
    wait_out(0, c0 + 1);
    chk("pair_drop_data", last_out[0].data, 64'h01A00050_10402030);

    // Odd tail: full beat then a 0x0F-keep beat.
    c1 = out_cnt[1]; c0 = out_cnt[0];
    send(B1, 1'b0, 1'b0, 1'b0);
    send(B3, 1'b0, 1'b0, 1'b0);
    send(B2, 1'b1, 1'b1, 1'b0);
    wait_out(1, c1 + 2);
    chk("tail_data", last_out[1].data, 64'h00000000_02A08050);
    chk("tail_keep", 64'(last_out[1].keep), 64'h0F);
    chk("tail_strb", 64'(last_out[1].strb), 64'h0F);
    chk("tail_last", 64'(last_out[1].last), 64'd1);
    chk("tail_user", 64'(last_out[1].user), 64'd1);
    wait_out(0, c0 + 2);
    chk("tail_drop_data", last_out[0].data, 64'h00000000_01A00050);

    // Sustained rate: 8 back-to-back beats take 8 cycles and give 4 outputs.
    idle(2);
    c1 = out_cnt[1];
    t0 = cyc;
    for (int i = 0; i < 8; i++) send({$urandom, $urandom}, 1'(i == 7), 1'b0, 1'b0);
    chk("throughput_cycles", 64'(cyc - t0), 64'd8);
    wait_out(1, c1 + 4);

    // Backpressure: 16-beat burst with random gaps, dst stalled 5 cycles.
    idle(2);
    c1 = out_cnt[1];
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send({$urandom, $urandom}, 1'(i == 15), 1'(i), 1'(i >> 1));
          idle(int'($urandom_range(0, 2)));
        end
      end
      begin
        idle(4);
        dst_if.t_ready = 1'b0;
        idle(5);
        dst_if.t_ready = 1'b1;
      end
    join
    wait_out(1, c1 + 8);

    // Reset while holding a half word.
    idle(2);
    send(B1, 1'b0, 1'b0, 1'b0);
    send(B2, 1'b0, 1'b1, 1'b1);
    send(B3, 1'b0, 1'b0, 1'b0);
    idle(1);
    #2 aresetn = 1'b0;
    #1 check_reset_outputs("async_reset");
    idle(2);
    aresetn = 1'b1;
    idle(1);
    c1 = out_cnt[1];
    send(B1, 1'b0, 1'b0, 1'b0);
    send(B2, 1'b1, 1'b0, 1'b0);
    wait_out(1, c1 + 1);
    chk("post_reset_data", last_out[1].data, 64'h02A08050_11402230);
    chk("post_reset_out_count", 64'(out_cnt[1] - c1), 64'd1);

    idle(5);
    chk("drain_q1", 64'(q1.size()), 64'd0);
    chk("drain_q0", 64'(q0.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/yuv444to422_packer.md
Name: yuv444to422_packer

Overview:
- Inverse of the 422→444 expander in the video stream chain.
- Accepts 64-bit Y'UV444 beats, each holding two pixels laid out as V, U, Y, 0x00 per 32-bit half.
- Reduces each pixel pair to one packed Y'UV422 word (Y0, U, Y1, V), then packs two such words per 64-bit output beat.
- Sits between the colour-processing stages and the DMA writer, so frame buffers are stored at 422 density.

Parameters:
DATA_WIDTH, 64, stream data width in bits; only 64 is supported, elaboration error otherwise.
USER_WIDTH, 1, t_user width, passed through.
DEST_WIDTH, 1, t_dest width, passed through.
AVERAGE, 1, 1 = chroma is the rounded mean of the pair; 0 = chroma taken from pixel 0 (drop).

Ports:
aclk  input  1  clock; all logic on the rising edge.
aresetn  input  1  reset, asynchronous, active-low.
src  nasti_stream_channel.slave  DATA_WIDTH  444 input stream (t_data, t_keep, t_strb, t_last, t_user, t_dest, t_valid, t_ready).
dst  nasti_stream_channel.master  DATA_WIDTH  422 output stream, same signal set.

Behaviour:
- Input byte map: [7:0]=V0, [15:8]=U0, [23:16]=Y0, [31:24] ignored; [39:32]=V1, [47:40]=U1, [55:48]=Y1, [63:56] ignored.
- Reduction, AVERAGE=1: U=(U0+U1+1)>>1 and V=(V0+V1+1)>>1, with the sum computed at 9 bits; no wrap, so 0xFF+0xFF gives 0xFF.
- Reduction, AVERAGE=0: U=U0, V=V0.
- 422 word: [7:0]=Y0, [15:8]=U, [23:16]=Y1, [31:24]=V.
- Packer FSM:
  - EMPTY: accepted beat with t_last=0 → store word in half register, go to HALF. Accepted beat with t_last=1 → load output with {32'h0, word}, t_keep=8'h0F, t_strb=8'h0F, t_last=1; stay EMPTY.
  - HALF: accepted beat → load output with {word, half}, t_keep=t_strb=8'hFF, t_last=src.t_last; go to EMPTY.
- src.t_ready = !dst.t_valid || dst.t_ready. It is a registered-state function only and never depends on src.t_valid.
- Output register:
  - Loads on an accepted beat that completes an output.
  - Clears dst.t_valid on a dst handshake with no new load.
  - A simultaneous handshake and load keeps dst.t_valid=1 with the new data, giving full throughput of one input beat per cycle.
  - dst data, keep, strb, last, user and dest stay stable while dst.t_valid && !dst.t_ready.
- Latency: dst.t_valid rises the cycle after the completing input beat is accepted.
- dst.t_user and dst.t_dest are taken from the completing input beat. dst.t_id='0.
- Input src.t_keep and src.t_strb must be all-ones; assert with $error otherwise, then process as if full.
- Reset values: dst.t_valid=0, dst.t_last=0, dst.t_data=0, dst.t_keep=0, dst.t_strb=0, dst.t_user=0, dst.t_dest=0, FSM=EMPTY, half register=0.
- Reset mid-packet discards the half word; the first beat after reset is treated as word 0 of a new output.
- t_last in HALF never produces a partial beat. t_last in EMPTY always produces the 0x0F-keep tail beat.

Decomposition:
- Shared package yuv_pkg:
  - typedef yuv444_px_t (packed v, u, y, pad bytes).
  - typedef yuv422_word_t (packed y0, u, y1, v).
  - function chroma_avg(a, b) returning 8 bits with round-half-up.
  - byte-lane constants shared with the 422→444 expander.
- Sub-module yuv444_pair_reduce: purely combinational, 64-bit pair in → yuv422_word_t out, AVERAGE parameter. The FSM and register stage stay in the top module.

Test Plan:
- AVERAGE=1, two beats: first 64'h00402312_00302010 → word 32'h11402230; second beat gives word W. Required: one output beat 64'h{W}11402230, keep 8'hFF, last as sent.
- AVERAGE=0, same first beat → word 32'h10402030; U1 and V1 ignored.
- Rounding: U0=0xFF, U1=0x00 → U=0x80. U0=U1=0xFF → U=0xFF. V0=0x01, V1=0x02 → V=0x02.
- Odd tail: three beats, last on the third. Required: one full beat, then beat 64'h00000000_{word2} with keep=8'h0F, strb=8'h0F, last=1.
- Backpressure: dst.t_ready held low 5 cycles during a 16-beat burst, with random src.t_valid gaps. Required:
  - no loss or duplication;
  - dst outputs stable while stalled;
  - src.t_ready=0 while output is full and stalled;
  - one output per two inputs at sustained rate.
- aresetn pulsed low while in HALF. Required: all outputs at reset values immediately (asynchronously); the next two beats pair together with no stale half word.
